mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 16-bit 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Non-memory ops pass straight through with no latency.
- Loads and stores run a req/ready handshake with the data memory. While the handshake is in progress, the block stalls the upstream stages and sends bubbles to MEM/WB.
- A watchdog counter aborts any access that hangs.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles waiting for dmem_ready before the access is aborted (1..65535).
- FAULT_DATA, 16'hDEAD: read data returned for a timed-out load.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_alu_result  in  16  ALU result; this is the address for memory ops.
- ex_write_data  in  16  store data.
- ex_rd  in  4  destination register.
- ex_reg_write  in  1  writeback enable.
- ex_mem_to_reg  in  1  writeback selects memory data.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- dmem_req  out  1  memory request; registered.
- dmem_we  out  1  1 = write; registered.
- dmem_addr  out  16  memory address; registered.
- dmem_wdata  out  16  write data; registered.
- dmem_rdata  in  16  read data; valid when dmem_ready = 1.
- dmem_ready  in  1  access complete; single-cycle pulse.
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM; combinational.
- mem_alu_result  out  16  to MEM/WB.
- mem_read_data  out  16  to MEM/WB.
- mem_rd  out  4  to MEM/WB.
- mem_reg_write  out  1  to MEM/WB.
- mem_mem_to_reg  out  1  to MEM/WB.
- mem_fault  out  1  sticky timeout flag; registered.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst = 0 at a clock edge):
  - State becomes IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_fault, the latched op registers and the wait counter all become 0.
  - While rst = 0: mem_stall = 0 and all MEM/WB outputs are 0.
  - Reset in BUSY drops dmem_req on that edge. A late dmem_ready arriving afterwards is ignored.
- Definitions:
  - memop = ex_valid & (ex_mem_read | ex_mem_write).
  - If ex_mem_read and ex_mem_write are both 1, the op is treated as a store.
- IDLE with !memop:
  - Pass-through, 0 latency: mem_alu_result = ex_alu_result, mem_read_data = 0, mem_rd = ex_rd.
  - mem_reg_write = ex_reg_write & ex_valid; mem_mem_to_reg = ex_mem_to_reg & ex_valid.
  - mem_stall = 0.
- IDLE with memop:
  - Combinationally: mem_stall = 1 and MEM/WB outputs are a bubble (all 0).
  - At the edge: latch alu_result, write_data, rd, reg_write, mem_to_reg and the store flag.
  - At the same edge: dmem_req <= 1, dmem_we <= store, dmem_addr <= ex_alu_result, dmem_wdata <= ex_write_data, counter <= 0, go to BUSY.
- BUSY:
  - mem_stall = 1; MEM/WB outputs are a bubble.
  - dmem_req and the address/data registers hold steady.
  - If dmem_ready: capture dmem_rdata into rdata_q (0 for stores), dmem_req <= 0, go to DONE.
  - Else if counter == TIMEOUT-1: rdata_q <= FAULT_DATA (loads) or 0 (stores), mem_fault <= 1, dmem_req <= 0, go to DONE.
  - Else: counter increments.
- DONE:
  - mem_stall = 0.
  - MEM/WB outputs present the latched op with mem_read_data = rdata_q.
  - Next state is IDLE unconditionally.
  - The EX/MEM input still shows the same op during DONE; it must not re-launch.
- Load latency: a load with ready on the first BUSY cycle spends 3 cycles in the stage (IDLE, BUSY, DONE), giving 2 stall cycles.
- dmem_ready in IDLE or DONE is ignored.
- mem_fault stays 1 until reset.
- dmem_addr, dmem_we and dmem_wdata retain their last values when dmem_req = 0.

Test Plan:
- ALU op (ex_valid = 1, alu_result = 16'h1234, rd = 5, reg_write = 1) -> same cycle: mem_alu_result = 16'h1234, mem_rd = 5, mem_reg_write = 1, mem_stall = 0, dmem_req stays 0.
- Load at addr 16'h0040, ready on the first BUSY cycle with rdata = 16'hBEEF -> mem_stall high for 2 cycles, dmem_req high exactly 1 cycle, DONE cycle shows mem_read_data = 16'hBEEF, mem_mem_to_reg = 1, mem_reg_write = 1.
- Store 16'hA5A5 to 16'h0100, ready after 4 BUSY cycles -> dmem_we = 1, dmem_addr/wdata stable across all 4 cycles, 5 stall cycles, bubbles (mem_reg_write = 0) while stalled.
- Load with dmem_ready never asserted, TIMEOUT = 8 -> exactly 8 BUSY cycles, then DONE with mem_read_data = 16'hDEAD, mem_fault = 1 and held; the next ALU op passes normally.
- rst = 0 during the 2nd BUSY cycle, then a dmem_ready pulse -> dmem_req = 0 after the edge, state IDLE, mem_stall = 0, no writeback emitted.
- Back-to-back loads (second presented right after DONE) -> second request launches in the following IDLE cycle; no duplicate request for the first load.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit pipeline: ALU results pass straight through, while loads and stores
// run a req/ready handshake with data memory that stalls upstream and is bounded by a watchdog.
module mem_access_stage #(
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [15:0] FAULT_DATA = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_alu_result,
    input  logic [15:0] ex_write_data,
    input  logic [3:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        mem_stall,
    output logic [15:0] mem_alu_result,
    output logic [15:0] mem_read_data,
    output logic [3:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_mem_to_reg,
    output logic        mem_fault
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] op_alu_q;
    logic [3:0]  op_rd_q;
    logic        op_reg_write_q;
    logic        op_mem_to_reg_q;
    logic        op_store_q;
    logic [15:0] rdata_q;
    logic [15:0] wait_cnt_q;
    logic        memop;
    logic        finish;

    assign memop = ex_valid & (ex_mem_read | ex_mem_write);
    // Access ends either on the memory's completion pulse or when the watchdog expires.
    assign finish = dmem_ready | (wait_cnt_q == TimeoutLast);

    always_comb begin
        state_d        = state_q;
        mem_stall      = 1'b0;
        mem_alu_result = '0;
        mem_read_data  = '0;
        mem_rd         = '0;
        mem_reg_write  = 1'b0;
        mem_mem_to_reg = 1'b0;
        if (rst) begin
            case (state_q)
                StIdle: begin
                    if (memop) begin
                        mem_stall = 1'b1;
                        state_d   = StBusy;
                    end else begin
                        mem_alu_result = ex_alu_result;
                        mem_rd         = ex_rd;
                        mem_reg_write  = ex_reg_write & ex_valid;
                        mem_mem_to_reg = ex_mem_to_reg & ex_valid;
                    end
                end
                StBusy: begin
                    mem_stall = 1'b1;
                    if (finish) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    // EX/MEM still holds this op here; going straight to IDLE avoids a relaunch.
                    mem_alu_result = op_alu_q;
                    mem_read_data  = rdata_q;
                    mem_rd         = op_rd_q;
                    mem_reg_write  = op_reg_write_q;
                    mem_mem_to_reg = op_mem_to_reg_q;
                    state_d        = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            mem_fault       <= 1'b0;
            op_alu_q        <= '0;
            op_rd_q         <= '0;
            op_reg_write_q  <= 1'b0;
            op_mem_to_reg_q <= 1'b0;
            op_store_q      <= 1'b0;
            rdata_q         <= '0;
            wait_cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (memop) begin
                        op_alu_q        <= ex_alu_result;
                        op_rd_q         <= ex_rd;
                        op_reg_write_q  <= ex_reg_write;
                        op_mem_to_reg_q <= ex_mem_to_reg;
                        op_store_q      <= ex_mem_write;
                        dmem_req        <= 1'b1;
                        dmem_we         <= ex_mem_write;
                        dmem_addr       <= ex_alu_result;
                        dmem_wdata      <= ex_write_data;
                        wait_cnt_q      <= '0;
                    end
                end
                StBusy: begin
                    if (dmem_ready) begin
                        rdata_q  <= op_store_q ? 16'h0000 : dmem_rdata;
                        dmem_req <= 1'b0;
                    end else if (wait_cnt_q == TimeoutLast) begin
                        rdata_q   <= op_store_q ? 16'h0000 : FAULT_DATA;
                        mem_fault <= 1'b1;
                        dmem_req  <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
